// File: rtl/disparity_wta_if.sv
// Stream interface for disparity_wta.
//   in_valid/in_ready/in_sad      : incoming SAD cost beats, one per candidate
//   out_valid/out_ready           : result handshake
//   out_disp/out_cost/out_cost2   : winning index, minimum cost, runner-up cost
// master = producer/consumer side (testbench), slave = the WTA block.
interface disparity_wta_if #(
    parameter int unsigned SAD_W  = 12,
    parameter int unsigned DISP_W = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [SAD_W-1:0]  in_sad;
    logic              out_valid;
    logic              out_ready;
    logic [DISP_W-1:0] out_disp;
    logic [SAD_W-1:0]  out_cost;
    logic [SAD_W-1:0]  out_cost2;

    modport master (
        output in_valid, in_sad, out_ready,
        input  in_ready, out_valid, out_disp, out_cost, out_cost2
    );

    modport slave (
        input  in_valid, in_sad, out_ready,
        output in_ready, out_valid, out_disp, out_cost, out_cost2
    );
endinterface

// File: rtl/disparity_wta.sv
// Winner-take-all disparity selection.
// Accumulates MAX_DISP SAD cost beats per pixel, tracking the minimum cost,
// its index (lowest index wins ties) and the smallest non-winning cost, then
// presents the result until consumed.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : disparity_wta_if.slave (input cost stream + result handshake)
module disparity_wta #(
    parameter int unsigned SAD_W    = 12,
    parameter int unsigned MAX_DISP = 64,
    parameter int unsigned DISP_W   = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    disparity_wta_if.slave   bus
);

    localparam logic [DISP_W-1:0] LAST = DISP_W'(MAX_DISP - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [DISP_W-1:0] cnt_q, cnt_d;
    logic [SAD_W-1:0]  best_q, best_d;
    logic [DISP_W-1:0] win_q, win_d;
    logic [SAD_W-1:0]  second_q, second_d;
    logic [DISP_W-1:0] odisp_q, odisp_d;
    logic [SAD_W-1:0]  ocost_q, ocost_d;
    logic [SAD_W-1:0]  ocost2_q, ocost2_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ACCUM;
            cnt_q    <= '0;
            best_q   <= '0;
            win_q    <= '0;
            second_q <= '0;
            odisp_q  <= '0;
            ocost_q  <= '0;
            ocost2_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            best_q   <= best_d;
            win_q    <= win_d;
            second_q <= second_d;
            odisp_q  <= odisp_d;
            ocost_q  <= ocost_d;
            ocost2_q <= ocost2_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        best_d   = best_q;
        win_d    = win_q;
        second_d = second_q;
        odisp_d  = odisp_q;
        ocost_d  = ocost_q;
        ocost2_d = ocost2_q;
        case (state_q)
            ACCUM: begin
                if (bus.in_valid) begin
                    if (cnt_q == '0) begin
                        best_d   = bus.in_sad;
                        win_d    = '0;
                        second_d = '1;
                    end else if (bus.in_sad < best_q) begin
                        second_d = best_q;
                        best_d   = bus.in_sad;
                        win_d    = cnt_q;
                    end else if (bus.in_sad < second_q) begin
                        second_d = bus.in_sad;
                    end
                    if (cnt_q == LAST) begin
                        // Result registers capture the post-update values so the
                        // outputs only change when a new result is presented.
                        cnt_d    = '0;
                        state_d  = HOLD;
                        odisp_d  = win_d;
                        ocost_d  = best_d;
                        ocost2_d = second_d;
                    end else begin
                        cnt_d = cnt_q + DISP_W'(1);
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // Handshake outputs decode the state register only: no out_ready->in_ready path.
    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_disp  = odisp_q;
    assign bus.out_cost  = ocost_q;
    assign bus.out_cost2 = ocost2_q;

endmodule

// File: tb/tb_disparity_wta.sv
module tb_disparity_wta;

    localparam int ND = 4;

    typedef int cost_t [ND];

    typedef struct {
        cost_t c;
        int    gap;
        int    disp;
        int    cost;
        int    cost2;
    } vec_t;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_fail;

    disparity_wta_if #(.SAD_W(12), .DISP_W(2)) bus ();

    disparity_wta #(.SAD_W(12), .MAX_DISP(ND), .DISP_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: lowest-index minimum, then minimum over every other candidate.
    function automatic void model(input cost_t c, output int d, output int m, output int m2);
        d = 0;
        m = c[0];
        for (int i = 1; i < ND; i++)
            if (c[i] < m) begin
                m = c[i];
                d = i;
            end
        m2 = 4095;
        for (int i = 0; i < ND; i++)
            if (i != d && c[i] < m2) m2 = c[i];
    endfunction

    task automatic beat(input int v);
        bus.in_valid = 1'b1;
        bus.in_sad   = v[11:0];
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_sad   = 12'h5A5;
    endtask

    task automatic send_pixel(input cost_t c, input int gap);
        for (int i = 0; i < ND; i++) begin
            check("in_ready_accum", int'(bus.in_ready), 1);
            check("out_valid_accum", int'(bus.out_valid), 0);
            beat(c[i]);
            if (i < ND - 1) repeat (gap) @(negedge clk);
        end
        check("latency_out_valid", int'(bus.out_valid), 1);
        check("hold_in_ready", int'(bus.in_ready), 0);
    endtask

    task automatic check_result(input string tag, input int d, input int m, input int m2);
        check({tag, "_disp"},  int'(bus.out_disp),  d);
        check({tag, "_cost"},  int'(bus.out_cost),  m);
        check({tag, "_cost2"}, int'(bus.out_cost2), m2);
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("consume_out_valid", int'(bus.out_valid), 0);
        check("consume_in_ready", int'(bus.in_ready), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, int'(bus.out_valid), 0);
        check({tag, "_in_ready"},  int'(bus.in_ready),  1);
        check_result(tag, 0, 0, 0);
    endtask

    vec_t  tbl [4];
    cost_t c;
    int    ed, em, em2;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sad    = '0;
        bus.out_ready = 1'b0;

        tbl[0] = '{c: '{510, 300, 700, 300},    gap: 0, disp: 1, cost: 300,  cost2: 300};
        tbl[1] = '{c: '{4095, 4095, 4095, 4095}, gap: 0, disp: 0, cost: 4095, cost2: 4095};
        tbl[2] = '{c: '{9, 8, 7, 6},            gap: 0, disp: 3, cost: 6,    cost2: 7};
        tbl[3] = '{c: '{100, 50, 200, 75},      gap: 3, disp: 1, cost: 50,   cost2: 75};

        #3;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 4; t++) begin
            send_pixel(tbl[t].c, tbl[t].gap);
            check_result($sformatf("vec%0d", t), tbl[t].disp, tbl[t].cost, tbl[t].cost2);
            consume();
        end

        // Gap-free run of the gapped vector gives the same answer.
        c = '{100, 50, 200, 75};
        send_pixel(c, 0);
        check_result("nogap", 1, 50, 75);
        consume();

        // Result held while junk arrives on the input side.
        c = '{50, 60, 70, 80};
        send_pixel(c, 0);
        bus.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.in_sad = 12'(k + 1);
            @(negedge clk);
            check("stall_out_valid", int'(bus.out_valid), 1);
            check("stall_in_ready", int'(bus.in_ready), 0);
            check_result("stall", 0, 50, 60);
        end
        bus.in_valid = 1'b0;
        consume();
        c = '{200, 100, 300, 400};
        send_pixel(c, 0);
        check_result("after_junk", 1, 100, 200);
        consume();

        // Reset after two accepted beats.
        beat(5);
        beat(6);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        check_reset_outputs("midreset_hold");
        rst_n = 1'b1;
        @(negedge clk);
        c = '{20, 10, 30, 40};
        send_pixel(c, 0);
        check_result("post_reset", 1, 10, 20);

        // Reset while a result is pending discards it.
        rst_n = 1'b0;
        #1;
        check_reset_outputs("hold_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("hold_reset_no_valid", int'(bus.out_valid), 0);

        // Back-to-back pixels with out_ready held high.
        bus.out_ready = 1'b1;
        c = '{7, 3, 3, 9};
        send_pixel(c, 0);
        check_result("b2b_a", 1, 3, 3);
        @(negedge clk);
        check("b2b_in_ready", int'(bus.in_ready), 1);
        check("b2b_out_valid", int'(bus.out_valid), 0);
        c = '{900, 800, 1000, 850};
        send_pixel(c, 0);
        check_result("b2b_b", 1, 800, 850);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("b2b_consumed", int'(bus.out_valid), 0);

        // Randomized pixels against the reference model.
        for (int p = 0; p < 25; p++) begin
            for (int i = 0; i < ND; i++)
                c[i] = (p % 3 == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 4095));
            model(c, ed, em, em2);
            send_pixel(c, int'($urandom_range(0, 2)));
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                check("rand_wait_valid", int'(bus.out_valid), 1);
            end
            check_result($sformatf("rand%0d", p), ed, em, em2);
            consume();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
